// File: rtl/period_meter_pkg.sv
// rtl/period_meter_pkg.sv - state encoding and sizing helper for period_meter
package period_meter_pkg;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ARM     = 2'd1;
    localparam logic [1:0] ST_MEASURE = 2'd2;
    localparam logic [1:0] ST_DONE    = 2'd3;

    // Bits needed to hold values 0 .. value-1 (minimum 1).
    function automatic int clog2(input longint unsigned value);
        int bits;
        longint unsigned v;
        bits = 0;
        v = (value > 0) ? value - 1 : 0;
        while (v > 0) begin
            bits = bits + 1;
            v = v >> 1;
        end
        return (bits < 1) ? 1 : bits;
    endfunction

endpackage

// File: rtl/sync_edge.sv
// rtl/sync_edge.sv - two-flop synchronizer with history flop and registered edge pulses
module sync_edge (
    input  logic clk_in,
    input  logic rst,
    input  logic sig_in,
    output logic rise,
    output logic fall
);

    logic sync_1;
    logic sync_2;
    logic hist;

    // Edge pulses are registered so every edge reaches the FSM with the same fixed delay.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            sync_1 <= 1'b0;
            sync_2 <= 1'b0;
            hist   <= 1'b0;
            rise   <= 1'b0;
            fall   <= 1'b0;
        end else begin
            sync_1 <= sig_in;
            sync_2 <= sync_1;
            hist   <= sync_2;
            rise   <= sync_2 & ~hist;
            fall   <= ~sync_2 & hist;
        end
    end

endmodule

// File: rtl/period_meter.sv
// rtl/period_meter.sv - measures period and high time of sig_in in clk_in cycles
module period_meter
    import period_meter_pkg::*;
#(
    parameter int unsigned CNT_W       = 32,
    parameter int unsigned TIMEOUT_CYC = 65_000_000
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             sig_in,
    input  logic             start,
    output logic             busy,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             timeout,
    output logic             valid,
    input  logic             ready
);

    localparam int              TO_W    = clog2(longint'(TIMEOUT_CYC) + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);

    generate
        if (CNT_W < 64 && (64'(TIMEOUT_CYC) >= (64'd1 << CNT_W))) begin : g_bad_timeout
            $error("TIMEOUT_CYC must be below 2**CNT_W");
        end
    endgenerate

    logic             rise;
    logic             fall;
    logic [1:0]       state;
    logic [TO_W-1:0]  to_cnt;
    logic [CNT_W-1:0] per_cnt;
    logic [CNT_W-1:0] hi_cnt;
    logic             high_seen;
    logic             to_hit;

    sync_edge u_sync_edge (
        .clk_in (clk_in),
        .rst    (rst),
        .sig_in (sig_in),
        .rise   (rise),
        .fall   (fall)
    );

    assign busy   = (state != ST_IDLE);
    assign to_hit = (to_cnt == TO_LAST);

    always_ff @(posedge clk_in) begin
        if (rst) begin
            state     <= ST_IDLE;
            to_cnt    <= '0;
            per_cnt   <= '0;
            hi_cnt    <= '0;
            high_seen <= 1'b0;
            period    <= '0;
            high_time <= '0;
            timeout   <= 1'b0;
            valid     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state  <= ST_ARM;
                        to_cnt <= '0;
                    end
                end
                ST_ARM: begin
                    if (rise) begin
                        state     <= ST_MEASURE;
                        per_cnt   <= CNT_W'(1);
                        hi_cnt    <= CNT_W'(1);
                        high_seen <= 1'b0;
                        to_cnt    <= '0;
                    end else if (to_hit) begin
                        state     <= ST_DONE;
                        period    <= '0;
                        high_time <= '0;
                        timeout   <= 1'b1;
                        valid     <= 1'b1;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                ST_MEASURE: begin
                    per_cnt <= per_cnt + 1'b1;
                    to_cnt  <= to_cnt + 1'b1;
                    if (!high_seen) begin
                        hi_cnt <= hi_cnt + 1'b1;
                    end
                    if (fall) begin
                        high_seen <= 1'b1;
                        high_time <= hi_cnt;
                    end
                    // A rise on the last allowed cycle still yields a real measurement.
                    if (rise) begin
                        state   <= ST_DONE;
                        period  <= per_cnt;
                        timeout <= 1'b0;
                        valid   <= 1'b1;
                        if (!high_seen) begin
                            high_time <= hi_cnt;
                        end
                    end else if (to_hit) begin
                        state     <= ST_DONE;
                        period    <= '0;
                        high_time <= '0;
                        timeout   <= 1'b1;
                        valid     <= 1'b1;
                    end
                end
                ST_DONE: begin
                    if (ready) begin
                        state <= ST_IDLE;
                        valid <= 1'b0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_period_meter.sv
// tb/tb_period_meter.sv - randomized self-checking bench for period_meter
module tb_period_meter;

    logic        clk_in = 1'b0;
    logic        rst;
    logic        sig_a, start_a, ready_a, busy_a, timeout_a, valid_a;
    logic [31:0] period_a, high_a;
    logic        sig_b, start_b, ready_b, busy_b, timeout_b, valid_b;
    logic [31:0] period_b, high_b;

    int passed = 0;
    int total  = 0;

    bit gen_on = 1'b0;
    int gen_p  = 10;
    int gen_h  = 5;
    int gen_ph = 0;

    always #5 clk_in = ~clk_in;

    period_meter #(.CNT_W(32), .TIMEOUT_CYC(5000)) u_dut_a (
        .clk_in(clk_in), .rst(rst), .sig_in(sig_a), .start(start_a), .busy(busy_a),
        .period(period_a), .high_time(high_a), .timeout(timeout_a), .valid(valid_a), .ready(ready_a)
    );

    period_meter #(.CNT_W(32), .TIMEOUT_CYC(100)) u_dut_b (
        .clk_in(clk_in), .rst(rst), .sig_in(sig_b), .start(start_b), .busy(busy_b),
        .period(period_b), .high_time(high_b), .timeout(timeout_b), .valid(valid_b), .ready(ready_b)
    );

    // Reference waveform: high for gen_h cycles, low for the rest of gen_p, edges on negedge.
    initial begin
        forever begin
            @(negedge clk_in);
            if (gen_on) begin
                sig_a  = (gen_ph < gen_h);
                gen_ph = (gen_ph + 1 >= gen_p) ? 0 : gen_ph + 1;
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic gen_restart(input int p, input int h);
        gen_on = 1'b0;
        sig_a  = 1'b0;
        repeat (4) begin @(posedge clk_in); #1; end
        gen_p  = p;
        gen_h  = h;
        gen_ph = 0;
        gen_on = 1'b1;
    endtask

    task automatic pulse_start(input bit use_b);
        if (use_b) start_b = 1'b1; else start_a = 1'b1;
        @(posedge clk_in); #1;
        start_a = 1'b0;
        start_b = 1'b0;
    endtask

    task automatic wait_valid(input bit use_b, input int budget, output int cycles, output bit ok);
        ok = 1'b0;
        cycles = 0;
        for (int i = 1; i <= budget; i++) begin
            @(posedge clk_in); #1;
            if ((use_b ? valid_b : valid_a) === 1'b1) begin
                ok = 1'b1;
                cycles = i;
                break;
            end
        end
    endtask

    task automatic accept(input bit use_b, input string name);
        if (use_b) ready_b = 1'b1; else ready_a = 1'b1;
        @(posedge clk_in); #1;
        ready_a = 1'b0;
        ready_b = 1'b0;
        total++;
        if ((use_b ? {busy_b, valid_b} : {busy_a, valid_a}) !== 2'b00)
            $display("FAIL %s_release: busy,valid=%b%b required 00", name,
                     use_b ? busy_b : busy_a, use_b ? valid_b : valid_a);
        else passed++;
    endtask

    task automatic check_result_a(input bit ok, input int exp_p, input int exp_h, input string name);
        total++;
        if (!ok) $display("FAIL %s_valid: valid not seen within budget", name);
        else passed++;
        total++;
        if (period_a !== 32'(exp_p)) $display("FAIL %s_period: got %0d required %0d", name, period_a, exp_p);
        else passed++;
        total++;
        if (high_a !== 32'(exp_h)) $display("FAIL %s_high: got %0d required %0d", name, high_a, exp_h);
        else passed++;
        total++;
        if (timeout_a !== 1'b0) $display("FAIL %s_timeout: got %b required 0", name, timeout_a);
        else passed++;
    endtask

    task automatic run_a(input int p, input int h, input bit restart, input string name);
        int  cyc;
        bit  ok;
        if (restart) gen_restart(p, h);
        repeat ($urandom_range(6, 0)) begin @(posedge clk_in); #1; end
        pulse_start(1'b0);
        wait_valid(1'b0, 2 * p + 40, cyc, ok);
        check_result_a(ok, p, h, name);
        accept(1'b0, name);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) begin @(posedge clk_in); #1; end
        total++;
        if ({busy_a, valid_a, timeout_a, period_a, high_a} !== 67'd0)
            $display("FAIL reset_a: busy=%b valid=%b timeout=%b period=%0d high=%0d required all 0",
                     busy_a, valid_a, timeout_a, period_a, high_a);
        else passed++;
        total++;
        if ({busy_b, valid_b, timeout_b, period_b, high_b} !== 67'd0)
            $display("FAIL reset_b: busy=%b valid=%b timeout=%b period=%0d high=%0d required all 0",
                     busy_b, valid_b, timeout_b, period_b, high_b);
        else passed++;
        rst = 1'b0;
        @(posedge clk_in); #1;
    endtask

    task automatic test_latency();
        int cyc;
        bit ok;
        gen_on = 1'b0;
        sig_a  = 1'b0;
        pulse_start(1'b0);
        repeat (2) begin @(posedge clk_in); #1; end
        @(negedge clk_in); sig_a = 1'b1;
        repeat (3) @(negedge clk_in);
        sig_a = 1'b0;
        repeat (5) @(negedge clk_in);
        sig_a = 1'b1;
        wait_valid(1'b0, 20, cyc, ok);
        total++;
        if (cyc != 4) $display("FAIL latency: got %0d cycles required 4", cyc);
        else passed++;
        check_result_a(ok, 3 + 5, 3, "manual");
        accept(1'b0, "manual");
        sig_a = 1'b0;
    endtask

    task automatic test_fixed_waves();
        run_a(1000, 500, 1'b1, "p1000");
        run_a(7, 2, 1'b1, "p7_first");
        run_a(7, 2, 1'b0, "p7_again");
        run_a(7, 2, 1'b0, "p7_third");
    endtask

    task automatic test_random();
        for (int k = 0; k < 8; k++) begin
            int p, h;
            p = $urandom_range(400, 3);
            h = $urandom_range(p - 1, 1);
            run_a(p, h, 1'b1, $sformatf("rand%0d_p%0d_h%0d", k, p, h));
        end
    endtask

    task automatic test_timeout_arm();
        int n;
        bit ok;
        sig_b = 1'b0;
        pulse_start(1'b1);
        total++;
        if (busy_b !== 1'b1) $display("FAIL to_arm_busy: got %b required 1", busy_b);
        else passed++;
        wait_valid(1'b1, 300, n, ok);
        total++;
        if (!ok || n != 100) $display("FAIL to_arm_cycles: got %0d (seen=%0d) required 100", n, ok);
        else passed++;
        total++;
        if ({timeout_b, period_b, high_b} !== {1'b1, 64'd0})
            $display("FAIL to_arm_result: timeout=%b period=%0d high=%0d required 1,0,0", timeout_b, period_b, high_b);
        else passed++;
        accept(1'b1, "to_arm");
    endtask

    task automatic test_timeout_measure();
        int n;
        bit ok;
        pulse_start(1'b1);
        repeat (2) begin @(posedge clk_in); #1; end
        @(negedge clk_in); sig_b = 1'b1;
        wait_valid(1'b1, 300, n, ok);
        total++;
        if (!ok || {timeout_b, period_b, high_b} !== {1'b1, 64'd0})
            $display("FAIL to_meas_result: seen=%0d timeout=%b period=%0d high=%0d required 1,1,0,0",
                     ok, timeout_b, period_b, high_b);
        else passed++;
        accept(1'b1, "to_meas");
        sig_b = 1'b0;
    endtask

    task automatic test_hold_and_ignore();
        int p, h, cyc;
        bit ok;
        p = $urandom_range(60, 10);
        h = $urandom_range(p - 1, 1);
        gen_restart(p, h);
        pulse_start(1'b0);
        wait_valid(1'b0, 2 * p + 40, cyc, ok);
        check_result_a(ok, p, h, "hold_entry");
        for (int i = 0; i < 50; i++) begin
            start_a = (i % 7 == 3);
            @(posedge clk_in); #1;
            total++;
            if (valid_a !== 1'b1 || busy_a !== 1'b1 || period_a !== 32'(p) || high_a !== 32'(h) || timeout_a !== 1'b0)
                $display("FAIL hold_c%0d: valid=%b busy=%b period=%0d high=%0d timeout=%b required 1,1,%0d,%0d,0",
                         i, valid_a, busy_a, period_a, high_a, timeout_a, p, h);
            else passed++;
        end
        start_a = 1'b1;
        accept(1'b0, "hold");
        start_a = 1'b0;
        repeat (3) begin @(posedge clk_in); #1; end
        total++;
        if (busy_a !== 1'b0) $display("FAIL handshake_start_ignored: busy=%b required 0", busy_a);
        else passed++;
    endtask

    task automatic test_reset_mid_measure();
        int p, h;
        gen_restart(200, 80);
        pulse_start(1'b0);
        repeat (100) begin @(posedge clk_in); #1; end
        rst = 1'b1;
        @(posedge clk_in); #1;
        rst = 1'b0;
        total++;
        if ({busy_a, valid_a, timeout_a, period_a, high_a} !== 67'd0)
            $display("FAIL mid_reset: busy=%b valid=%b timeout=%b period=%0d high=%0d required all 0",
                     busy_a, valid_a, timeout_a, period_a, high_a);
        else passed++;
        p = $urandom_range(120, 5);
        h = $urandom_range(p - 1, 1);
        run_a(p, h, 1'b1, "after_reset");
    endtask

    initial begin
        rst     = 1'b1;
        sig_a   = 1'b0;
        sig_b   = 1'b0;
        start_a = 1'b0;
        start_b = 1'b0;
        ready_a = 1'b0;
        ready_b = 1'b0;
        test_reset();
        test_latency();
        test_fixed_waves();
        test_random();
        test_timeout_arm();
        test_timeout_measure();
        test_hold_and_ignore();
        test_reset_mid_measure();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
